// File: rtl/dma_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dma_stream_fifo
// Brief    : FWFT DMA stream buffer with occupancy flags, burst-admission
//            checks, synchronous flush and peak-occupancy monitor.
// Revision : 2.0
// ============================================================================
module dma_stream_fifo #(
    parameter  int DATA_WIDTH   = 32,
    parameter  int DEPTH        = 16,
    parameter  int AFULL_LEVEL  = DEPTH - 2,
    parameter  int AEMPTY_LEVEL = 2,
    localparam int CW           = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CW-1:0]         level,
    output logic [CW-1:0]         free,
    output logic                  almost_full,
    output logic                  almost_empty,
    input  logic [CW-1:0]         wr_beats,
    output logic                  space_ok,
    input  logic [CW-1:0]         rd_beats,
    output logic                  data_ok,
    output logic [CW-1:0]         peak_level
);

    localparam logic [CW-1:0] c_DEPTH  = CW'(DEPTH);
    localparam logic [CW-1:0] c_AFULL  = CW'(AFULL_LEVEL);
    localparam logic [CW-1:0] c_AEMPTY = CW'(AEMPTY_LEVEL);
    localparam logic [CW-1:0] c_ONE    = CW'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_level;
    logic [CW-1:0]         r_peak;

    logic [CW-2:0]         w_wr_idx;
    logic [CW-2:0]         w_rd_idx;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [CW-1:0]         w_level_nxt;

    assign w_wr_idx = r_wr_ptr[CW-2:0];
    assign w_rd_idx = r_rd_ptr[CW-2:0];
    assign w_full   = (r_wr_ptr[CW-1] != r_rd_ptr[CW-1]) && (w_wr_idx == w_rd_idx);
    assign w_empty  = (r_wr_ptr == r_rd_ptr);

    // Flush overrides both handshakes so neither side sees a transfer.
    assign w_push = s_valid && !w_full  && !flush;
    assign w_pop  = m_ready && !w_empty && !flush;

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + c_ONE;
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - c_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_peak   <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_peak   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ONE;
            end
            r_level <= w_level_nxt;
            // Level never exceeds DEPTH, so the peak saturates on its own.
            if (w_level_nxt > r_peak) begin
                r_peak <= w_level_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wr_idx] <= s_data;
        end
    end

    assign s_ready      = !w_full;
    assign m_valid      = !w_empty;
    assign m_data       = r_mem[w_rd_idx];
    assign level        = r_level;
    assign free         = c_DEPTH - r_level;
    assign almost_full  = (r_level >= c_AFULL);
    assign almost_empty = (r_level <= c_AEMPTY);
    assign space_ok     = (free >= wr_beats);
    assign data_ok      = (r_level >= rd_beats);
    assign peak_level   = r_peak;

endmodule
`default_nettype wire

// File: tb/tb_dma_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_stream_fifo
// Brief    : Scoreboard bench for dma_stream_fifo (ordering, flags, flush).
// Revision : 2.0
// ============================================================================
module tb_dma_stream_fifo;

    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 16;
    localparam int CW         = 5;

    logic                  clk;
    logic                  rst_n;
    logic                  flush;
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;
    logic [CW-1:0]         level;
    logic [CW-1:0]         free;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         wr_beats;
    logic                  space_ok;
    logic [CW-1:0]         rd_beats;
    logic                  data_ok;
    logic [CW-1:0]         peak_level;

    dma_stream_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .level        (level),
        .free         (free),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .wr_beats     (wr_beats),
        .space_ok     (space_ok),
        .rd_beats     (rd_beats),
        .data_ok      (data_ok),
        .peak_level   (peak_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_WIDTH-1:0] q_exp [$];
    int                    m_peak = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: decisions are taken from the model occupancy, never
    // from the DUT handshake outputs.
    int  sz;
    bit  do_push;
    bit  do_pop;
    always @(negedge clk) begin
        if (rst_n) begin
            sz = q_exp.size();
            check("s_ready",      32'(s_ready),      32'(sz < DEPTH));
            check("m_valid",      32'(m_valid),      32'(sz > 0));
            check("level",        32'(level),        32'(sz));
            check("free",         32'(free),         32'(DEPTH - sz));
            check("almost_full",  32'(almost_full),  32'(sz >= DEPTH - 2));
            check("almost_empty", 32'(almost_empty), 32'(sz <= 2));
            check("peak_level",   32'(peak_level),   32'(m_peak));
            do_pop  = (sz > 0) && m_ready;
            do_push = s_valid && (sz < DEPTH);
            if (do_pop) begin
                check("m_data", m_data, q_exp[0]);
            end
            if (flush) begin
                q_exp.delete();
                m_peak = 0;
            end else begin
                if (do_pop) begin
                    void'(q_exp.pop_front());
                end
                if (do_push) begin
                    q_exp.push_back(s_data);
                end
                if (q_exp.size() > m_peak) begin
                    m_peak = q_exp.size();
                end
            end
        end
    end

    task automatic check_cleared(input string tag);
        check({tag, "_level"},  32'(level),        32'd0);
        check({tag, "_free"},   32'(free),         32'(DEPTH));
        check({tag, "_mvalid"}, 32'(m_valid),      32'd0);
        check({tag, "_sready"}, 32'(s_ready),      32'd1);
        check({tag, "_aempty"}, 32'(almost_empty), 32'd1);
        check({tag, "_afull"},  32'(almost_full),  32'd0);
        check({tag, "_peak"},   32'(peak_level),   32'd0);
    endtask

    logic [DATA_WIDTH-1:0] seq;

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        m_ready  = 1'b0;
        wr_beats = '0;
        rd_beats = '0;
        #2;
        check_cleared("reset");
        step(2);
        rst_n = 1'b1;
        step(1);

        // Fill 0x00..0x0F, then offer a 17th beat that must be refused.
        for (int i = 0; i < 17; i++) begin
            s_valid = 1'b1;
            s_data  = 32'(i);
            step(1);
        end
        s_valid = 1'b0;
        check("full_level", 32'(level),      32'd16);
        check("full_peak",  32'(peak_level), 32'd16);
        check("full_free",  32'(free),       32'd0);

        // Drain in order.
        m_ready = 1'b1;
        step(17);
        m_ready = 1'b0;
        check("drained_mvalid", 32'(m_valid), 32'd0);

        // Push into empty while consumer is ready: no same-cycle bypass.
        s_valid = 1'b1;
        s_data  = 32'hA5;
        m_ready = 1'b1;
        check("bypass_mvalid", 32'(m_valid), 32'd0);
        step(1);
        s_valid = 1'b0;
        check("fwft_mvalid", 32'(m_valid), 32'd1);
        check("fwft_mdata",  m_data,       32'hA5);
        step(2);
        m_ready = 1'b0;

        // Streaming at level 5.
        seq = 32'h1000;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = seq;
            seq++;
            step(1);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            s_data = $urandom;
            step(1);
        end
        m_ready = 1'b0;
        check("stream5_level", 32'(level), 32'd5);

        // Fill to full, then stream with s_valid held at full.
        for (int i = 0; i < 13; i++) begin
            s_data = seq;
            seq++;
            step(1);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_data = seq;
            seq++;
            step(1);
        end
        s_valid = 1'b0;
        m_ready = 1'b0;

        // Flush, then build level 10 for burst-admission checks.
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_data  = 32'h2000 + 32'(i);
            step(1);
        end
        s_valid = 1'b0;
        check("burst_level", 32'(level), 32'd10);
        wr_beats = 5'd6;  #1; check("space_ok_6",  32'(space_ok), 32'd1);
        wr_beats = 5'd7;  #1; check("space_ok_7",  32'(space_ok), 32'd0);
        wr_beats = 5'd0;  #1; check("space_ok_0",  32'(space_ok), 32'd1);
        wr_beats = 5'd17; #1; check("space_ok_17", 32'(space_ok), 32'd0);
        rd_beats = 5'd10; #1; check("data_ok_10",  32'(data_ok),  32'd1);
        rd_beats = 5'd11; #1; check("data_ok_11",  32'(data_ok),  32'd0);
        rd_beats = 5'd0;  #1; check("data_ok_0",   32'(data_ok),  32'd1);
        rd_beats = 5'd17; #1; check("data_ok_17",  32'(data_ok),  32'd0);
        step(1);

        // Down to 9, then flush with both handshakes asserted.
        m_ready = 1'b1;
        step(1);
        s_valid = 1'b1;
        s_data  = 32'hDEAD;
        flush   = 1'b1;
        step(1);
        flush   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        check_cleared("flush");
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = 32'h3000 + 32'(i);
            step(1);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        step(4);

        // Asynchronous reset mid-stream.
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_valid = 1'b1;
            s_data  = 32'h4000 + 32'(i);
            step(1);
        end
        m_ready = 1'b1;
        step(3);
        rst_n = 1'b0;
        #1;
        check_cleared("arst");
        q_exp.delete();
        m_peak  = 0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        step(2);
        rst_n = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'h5A5A;
        step(1);
        s_valid = 1'b0;
        m_ready = 1'b1;
        step(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dma_stream_fifo.md
Name: dma_stream_fifo

Overview:
- Second-generation DMA data buffer between the AXI read-channel FSM (producer) and the AXI write-channel FSM (consumer).
- Valid/ready handshakes on both sides and first-word-fall-through output.
- Registered occupancy, free-space and threshold flags, plus burst-admission checks so each FSM can decide before issuing an AR/AW burst.
- Synchronous flush for channel abort and a peak-occupancy monitor for performance tuning.

Parameters:
- DATA_WIDTH, 32, payload width in bits.
- DEPTH, 16, number of entries; power of 2, >= 2.
- AFULL_LEVEL, DEPTH-2, almost_full asserts when level >= AFULL_LEVEL.
- AEMPTY_LEVEL, 2, almost_empty asserts when level <= AEMPTY_LEVEL.
- CW (localparam), $clog2(DEPTH)+1, count width.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of contents.
- s_valid  in  1  producer has a beat.
- s_data  in  DATA_WIDTH  producer beat.
- s_ready  out  1  FIFO can accept a beat (= !full).
- m_valid  out  1  head entry valid (= !empty).
- m_data  out  DATA_WIDTH  head entry, FWFT.
- m_ready  in  1  consumer takes the head.
- level  out  CW  entries stored.
- free  out  CW  DEPTH - level.
- almost_full  out  1  level >= AFULL_LEVEL.
- almost_empty  out  1  level <= AEMPTY_LEVEL.
- wr_beats  in  CW  burst length the read FSM intends to fetch.
- space_ok  out  1  free >= wr_beats.
- rd_beats  in  CW  burst length the write FSM intends to drain.
- data_ok  out  1  level >= rd_beats.
- peak_level  out  CW  highest level reached since reset/flush.

Behaviour:
- Storage:
  - Register array with CW-bit wr_ptr/rd_ptr; the MSB is the wrap bit.
  - Index = ptr[CW-2:0]. Pointers wrap naturally modulo 2*DEPTH.
  - full = MSBs differ and indices equal. empty = pointers equal.
- Push and pop:
  - push = s_valid & s_ready. pop = m_valid & m_ready.
  - Push writes mem[wr_idx] and increments wr_ptr. Pop increments rd_ptr.
- Output path:
  - m_data = mem[rd_idx] combinationally, so no read latency.
  - m_data is don't-care when m_valid=0 but must not be X after the first write.
- Latency: a beat pushed in cycle N is visible on m_valid/m_data in cycle N+1. No same-cycle bypass when empty.
- Full:
  - s_ready=0, so no push occurs even if a pop happens in the same cycle.
  - s_ready rises the cycle after the pop.
- Empty: m_valid=0; m_ready is ignored.
- Simultaneous push and pop (neither full nor empty): both pointers advance and level is unchanged.
- level:
  - Registered: +1 on push only, -1 on pop only, otherwise held.
  - Range 0..DEPTH; it must equal wr_ptr - rd_ptr at all times.
- Derived outputs:
  - free, almost_full and almost_empty are decoded from registered level, with no combinational path from s_valid/m_ready.
  - space_ok and data_ok are combinational compares against the registered level and the current wr_beats/rd_beats.
  - wr_beats=0 gives space_ok=1; rd_beats=0 gives data_ok=1; values > DEPTH give 0.
- peak_level:
  - Registered. Updates to the next level whenever next level > peak_level.
  - Cleared with flush. Saturates at DEPTH.
- flush:
  - Has priority over push/pop in its cycle: the push is discarded and the pop is not counted as a transfer.
  - Next cycle: pointers=0, level=0, peak_level=0, m_valid=0, s_ready=1. Memory contents are not cleared.
- Reset values (asynchronous, immediate on rst_n low):
  - Pointers 0, level 0, peak_level 0.
  - m_valid=0, s_ready=1, free=DEPTH.
  - almost_empty=1; almost_full=0 (for AFULL_LEVEL>0).
  - Memory is not reset. Reset mid-burst discards all contents.
- Handshake rule: s_data/m_data transfer only on valid&ready. The FIFO never drops an accepted beat and never duplicates a popped one.

Test Plan:
- Reset, then push 0x00..0x0F back-to-back with m_ready=0:
  - s_ready drops after the 16th push; level=16, free=0, almost_full from level 14, peak_level=16.
  - A 17th s_valid is not accepted.
- From full, hold m_ready=1 with s_valid=0:
  - m_data reads 0x00..0x0F in order, one per cycle; m_valid=0 after 16 pops; almost_empty when level<=2.
- Push 0xA5 into empty while m_ready=1: m_valid=0 in the push cycle, m_valid=1 with m_data=0xA5 next cycle, popped that cycle.
- Streaming at level 5 with s_valid=m_ready=1 for 100 cycles: level stays 5, ordering intact. Repeat at level 16 with s_valid held: no push until a pop frees a slot.
- Burst checks at level 10: wr_beats=6 gives space_ok=1, wr_beats=7 gives space_ok=0; rd_beats=10 gives data_ok=1, rd_beats=11 gives data_ok=0.
- Fill to 9, assert flush together with s_valid and m_ready: next cycle level=0, peak_level=0, m_valid=0. The flushed-cycle beat is absent. Assert rst_n low mid-stream and get the same cleared state immediately.
